// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS multicycle memory interface.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    localparam int DATA_W = 32;

    // Read data returned when an access is aborted by the timeout.
    localparam logic [DATA_W-1:0] MEMIF_POISON = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } memif_state_t;

endpackage

// File: rtl/mips_mem_if_if.sv
// Bundle of control-FSM side and RAM side signals of the memory interface.
// Latency: n/a (wiring only).
// Backpressure: the stall signal holds the control FSM; ram_req is held until ram_ack.
//
// CPU side : memread, memwrite, addr, wdata -> mem_rdata, mem_ready, stall, mem_err
// RAM side : ram_req, ram_we, ram_addr, ram_wdata -> ram_ack, ram_rdata
// master = environment (control FSM + RAM), slave = mips_mem_if.
interface mips_mem_if_if
    import mips_pkg::*;
#(
    parameter int AW = 10
);
    logic              memread;
    logic              memwrite;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall;
    logic              mem_err;
    logic              ram_req;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ack;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output memread, memwrite, addr, wdata, ram_ack, ram_rdata,
        input  mem_rdata, mem_ready, stall, mem_err,
               ram_req, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  memread, memwrite, addr, wdata, ram_ack, ram_rdata,
        output mem_rdata, mem_ready, stall, mem_err,
               ram_req, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mips_mem_if.sv
// Multicycle memory interface: turns level memread/memwrite into a held RAM req/ack access.
// Latency: request in IDLE cycle t, ram_ack in cycle t+k (k>=1) -> mem_ready pulse at t+k+1.
// Backpressure: stall (combinational) holds the control FSM until the access completes.
//
// Ports: clk, reset (synchronous, active-high), bus (mips_mem_if_if.slave).
// Optional feature: define MEMIF_TIMEOUT_EN to abort a REQ lasting TIMEOUT cycles
// with poisoned read data and a sticky mem_err; otherwise REQ waits forever.
module mips_mem_if
    import mips_pkg::*;
#(
    parameter int AW      = 10,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    mips_mem_if_if.slave  bus
);

    memif_state_t      r_state;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_mem_ready;
    logic              r_ram_req;
    logic              r_ram_we;
    logic [AW-1:0]     r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              w_req;
    logic              w_unused;

    assign w_req = bus.memread | bus.memwrite;

    // Byte-lane and upper address bits play no part in a word access.
    assign w_unused = ^{bus.addr[DATA_W-1:AW+2], bus.addr[1:0]};

`ifdef MEMIF_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_timer;
    logic          r_mem_err;
`else
    logic [31:0]   w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mem_rdata <= '0;
            r_mem_ready <= 1'b0;
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
`ifdef MEMIF_TIMEOUT_EN
            r_timer     <= '0;
            r_mem_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_mem_ready <= 1'b0;
                    if (w_req) begin
                        r_ram_addr  <= bus.addr[AW+1:2];
                        r_ram_wdata <= bus.wdata;
                        r_ram_we    <= bus.memwrite;
                        r_ram_req   <= 1'b1;
                        r_state     <= REQ;
`ifdef MEMIF_TIMEOUT_EN
                        r_timer     <= '0;
`endif
                    end
                end
                REQ: begin
                    // An ack in the timeout cycle still completes normally.
                    if (bus.ram_ack) begin
                        if (!r_ram_we) begin
                            r_mem_rdata <= bus.ram_rdata;
                        end
                        r_ram_req   <= 1'b0;
                        r_mem_ready <= 1'b1;
                        r_state     <= DONE;
                    end
`ifdef MEMIF_TIMEOUT_EN
                    else if (r_timer == TW'(TIMEOUT - 1)) begin
                        if (!r_ram_we) begin
                            r_mem_rdata <= MEMIF_POISON;
                        end
                        r_ram_req   <= 1'b0;
                        r_mem_ready <= 1'b1;
                        r_mem_err   <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
`endif
                end
                DONE: begin
                    // A request still high here is the one just served; IDLE re-detects the next.
                    r_mem_ready <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        case (r_state)
            IDLE:    bus.stall = w_req;
            REQ:     bus.stall = 1'b1;
            default: bus.stall = 1'b0;
        endcase
    end

    assign bus.mem_rdata = r_mem_rdata;
    assign bus.mem_ready = r_mem_ready;
    assign bus.ram_req   = r_ram_req;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
`ifdef MEMIF_TIMEOUT_EN
    assign bus.mem_err   = r_mem_err;
`else
    assign bus.mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mem_if.sv
// Directed testbench for mips_mem_if: reset, read, write, priority, back-to-back, reset abort, timeout.
// Latency: inputs driven 1ns after posedge, outputs sampled in the same settled window.
// Backpressure: the bench plays both the control FSM and the RAM.
module tb_mips_mem_if;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    mips_mem_if_if #(.AW(10)) bus ();

    mips_mem_if #(.AW(10), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.addr      = 32'h0;
        bus.wdata     = 32'h0;
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        n_total++; if (bus.ram_req !== 1'b0) $display("FAIL rst_ram_req: got %b want 0", bus.ram_req); else n_pass++;
        n_total++; if (bus.ram_we !== 1'b0) $display("FAIL rst_ram_we: got %b want 0", bus.ram_we); else n_pass++;
        n_total++; if (bus.ram_addr !== 10'h0) $display("FAIL rst_ram_addr: got %h want 0", bus.ram_addr); else n_pass++;
        n_total++; if (bus.ram_wdata !== 32'h0) $display("FAIL rst_ram_wdata: got %h want 0", bus.ram_wdata); else n_pass++;
        n_total++; if (bus.mem_rdata !== 32'h0) $display("FAIL rst_mem_rdata: got %h want 0", bus.mem_rdata); else n_pass++;
        n_total++; if (bus.mem_ready !== 1'b0) $display("FAIL rst_mem_ready: got %b want 0", bus.mem_ready); else n_pass++;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", bus.stall); else n_pass++;
        n_total++; if (bus.mem_err !== 1'b0) $display("FAIL rst_mem_err: got %b want 0", bus.mem_err); else n_pass++;
        step();
    endtask

    // Read of byte address 0x10 with the RAM acking in the third REQ cycle.
    task automatic test_read();
        int stall_cnt;
        stall_cnt   = 0;
        bus.memread = 1'b1;
        bus.addr    = 32'h0000_0010;
        for (int c = 0; c < 4; c++) begin
            bus.ram_ack   = (c == 3);
            bus.ram_rdata = (c == 3) ? 32'h1234_5678 : 32'h0;
            #1;
            if (bus.stall === 1'b1) stall_cnt++;
            n_total++; if (bus.mem_ready !== 1'b0) $display("FAIL read_early_ready_c%0d: got %b want 0", c, bus.mem_ready); else n_pass++;
            if (c == 1) begin
                n_total++; if (bus.ram_req !== 1'b1) $display("FAIL read_ram_req: got %b want 1", bus.ram_req); else n_pass++;
                n_total++; if (bus.ram_addr !== 10'd4) $display("FAIL read_ram_addr: got %0d want 4", bus.ram_addr); else n_pass++;
                n_total++; if (bus.ram_we !== 1'b0) $display("FAIL read_ram_we: got %b want 0", bus.ram_we); else n_pass++;
            end
            step();
        end
        bus.ram_ack = 1'b0;
        bus.memread = 1'b0;
        #1;
        n_total++; if (stall_cnt !== 4) $display("FAIL read_stall_cycles: got %0d want 4", stall_cnt); else n_pass++;
        n_total++; if (bus.mem_ready !== 1'b1) $display("FAIL read_ready: got %b want 1", bus.mem_ready); else n_pass++;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL read_done_stall: got %b want 0", bus.stall); else n_pass++;
        n_total++; if (bus.ram_req !== 1'b0) $display("FAIL read_req_drop: got %b want 0", bus.ram_req); else n_pass++;
        n_total++; if (bus.mem_rdata !== 32'h1234_5678) $display("FAIL read_rdata: got %h want 12345678", bus.mem_rdata); else n_pass++;
        step();
        n_total++; if (bus.mem_ready !== 1'b0) $display("FAIL read_ready_pulse: got %b want 0", bus.mem_ready); else n_pass++;
    endtask

    // Write with immediate ack; wdata changes during REQ to prove it was latched.
    task automatic test_write();
        bus.memwrite = 1'b1;
        bus.addr     = 32'h0000_0008;
        bus.wdata    = 32'hCAFE_F00D;
        #1;
        n_total++; if (bus.stall !== 1'b1) $display("FAIL write_idle_stall: got %b want 1", bus.stall); else n_pass++;
        step();
        bus.wdata   = 32'h0;
        bus.addr    = 32'h0000_03FC;
        bus.ram_ack = 1'b1;
        bus.ram_rdata = 32'h7777_7777;
        #1;
        n_total++; if (bus.ram_we !== 1'b1) $display("FAIL write_ram_we: got %b want 1", bus.ram_we); else n_pass++;
        n_total++; if (bus.ram_addr !== 10'd2) $display("FAIL write_ram_addr: got %0d want 2", bus.ram_addr); else n_pass++;
        n_total++; if (bus.ram_wdata !== 32'hCAFE_F00D) $display("FAIL write_ram_wdata: got %h want cafef00d", bus.ram_wdata); else n_pass++;
        n_total++; if (bus.ram_req !== 1'b1) $display("FAIL write_ram_req: got %b want 1", bus.ram_req); else n_pass++;
        step();
        idle_inputs();
        #1;
        n_total++; if (bus.mem_ready !== 1'b1) $display("FAIL write_ready_2cyc: got %b want 1", bus.mem_ready); else n_pass++;
        n_total++; if (bus.mem_rdata !== 32'h1234_5678) $display("FAIL write_rdata_kept: got %h want 12345678", bus.mem_rdata); else n_pass++;
        step();
    endtask

    // memread and memwrite together: the write wins.
    task automatic test_both();
        bus.memread  = 1'b1;
        bus.memwrite = 1'b1;
        bus.addr     = 32'h0000_0020;
        bus.wdata    = 32'h0BAD_F00D;
        step();
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 32'h5555_5555;
        #1;
        n_total++; if (bus.ram_we !== 1'b1) $display("FAIL both_ram_we: got %b want 1", bus.ram_we); else n_pass++;
        n_total++; if (bus.ram_addr !== 10'd8) $display("FAIL both_ram_addr: got %0d want 8", bus.ram_addr); else n_pass++;
        step();
        idle_inputs();
        #1;
        n_total++; if (bus.mem_ready !== 1'b1) $display("FAIL both_ready: got %b want 1", bus.mem_ready); else n_pass++;
        n_total++; if (bus.mem_rdata !== 32'h1234_5678) $display("FAIL both_rdata_kept: got %h want 12345678", bus.mem_rdata); else n_pass++;
        step();
    endtask

    // Write, then memread raised in DONE and held: one read issued from the following IDLE.
    task automatic test_back_to_back();
        int req_rises;
        logic prev_req;
        bus.memwrite = 1'b1;
        bus.addr     = 32'h0000_000C;
        bus.wdata    = 32'h1111_2222;
        step();
        bus.ram_ack = 1'b1;
        step();
        bus.ram_ack  = 1'b0;
        bus.memwrite = 1'b0;
        bus.memread  = 1'b1;
        bus.addr     = 32'h0000_0040;
        #1;
        n_total++; if (bus.mem_ready !== 1'b1) $display("FAIL b2b_write_ready: got %b want 1", bus.mem_ready); else n_pass++;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL b2b_done_stall: got %b want 0", bus.stall); else n_pass++;
        step();
        #1;
        n_total++; if (bus.ram_req !== 1'b0) $display("FAIL b2b_done_ignored: got %b want 0", bus.ram_req); else n_pass++;
        n_total++; if (bus.stall !== 1'b1) $display("FAIL b2b_idle_stall: got %b want 1", bus.stall); else n_pass++;
        step();
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 32'hA5A5_0001;
        #1;
        n_total++; if (bus.ram_we !== 1'b0) $display("FAIL b2b_read_we: got %b want 0", bus.ram_we); else n_pass++;
        n_total++; if (bus.ram_addr !== 10'd16) $display("FAIL b2b_read_addr: got %0d want 16", bus.ram_addr); else n_pass++;
        step();
        bus.ram_ack = 1'b0;
        bus.memread = 1'b0;
        #1;
        n_total++; if (bus.mem_ready !== 1'b1) $display("FAIL b2b_read_ready: got %b want 1", bus.mem_ready); else n_pass++;
        n_total++; if (bus.mem_rdata !== 32'hA5A5_0001) $display("FAIL b2b_read_rdata: got %h want a5a50001", bus.mem_rdata); else n_pass++;
        req_rises = 0;
        prev_req  = bus.ram_req;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.ram_req === 1'b1 && prev_req !== 1'b1) req_rises++;
            prev_req = bus.ram_req;
        end
        n_total++; if (req_rises !== 0) $display("FAIL b2b_extra_req: got %0d want 0", req_rises); else n_pass++;
    endtask

    // Reset while in REQ aborts; a late ack must not produce mem_ready.
    task automatic test_reset_mid();
        bus.memread = 1'b1;
        bus.addr    = 32'h0000_0100;
        step();
        #1;
        n_total++; if (bus.ram_req !== 1'b1) $display("FAIL rmid_req_before: got %b want 1", bus.ram_req); else n_pass++;
        reset       = 1'b1;
        bus.memread = 1'b0;
        step();
        reset         = 1'b0;
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 32'h9999_9999;
        #1;
        n_total++; if (bus.ram_req !== 1'b0) $display("FAIL rmid_req_drop: got %b want 0", bus.ram_req); else n_pass++;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL rmid_stall: got %b want 0", bus.stall); else n_pass++;
        n_total++; if (bus.mem_ready !== 1'b0) $display("FAIL rmid_ready0: got %b want 0", bus.mem_ready); else n_pass++;
        step();
        #1;
        n_total++; if (bus.mem_ready !== 1'b0) $display("FAIL rmid_late_ack_ready: got %b want 0", bus.mem_ready); else n_pass++;
        n_total++; if (bus.mem_rdata !== 32'h0) $display("FAIL rmid_rdata: got %h want 0", bus.mem_rdata); else n_pass++;
        idle_inputs();
        step();
    endtask

`ifdef MEMIF_TIMEOUT_EN
    // TIMEOUT=8: eight REQ cycles without ack, then poisoned completion and sticky error.
    task automatic test_timeout();
        int req_cycles;
        req_cycles  = 0;
        bus.memread = 1'b1;
        bus.addr    = 32'h0000_0004;
        step();
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.ram_req !== 1'b1) break;
            req_cycles++;
            step();
        end
        bus.memread = 1'b0;
        #1;
        n_total++; if (req_cycles !== 8) $display("FAIL to_req_cycles: got %0d want 8", req_cycles); else n_pass++;
        n_total++; if (bus.mem_ready !== 1'b1) $display("FAIL to_ready: got %b want 1", bus.mem_ready); else n_pass++;
        n_total++; if (bus.mem_rdata !== 32'hDEAD_BEEF) $display("FAIL to_poison: got %h want deadbeef", bus.mem_rdata); else n_pass++;
        n_total++; if (bus.mem_err !== 1'b1) $display("FAIL to_err: got %b want 1", bus.mem_err); else n_pass++;
        step();
        step();
        n_total++; if (bus.mem_err !== 1'b1) $display("FAIL to_err_sticky: got %b want 1", bus.mem_err); else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_total++; if (bus.mem_err !== 1'b0) $display("FAIL to_err_reset: got %b want 0", bus.mem_err); else n_pass++;
        step();
    endtask
`else
    // Without the timeout, REQ holds for as long as the RAM takes.
    task automatic test_no_timeout();
        bus.memread = 1'b1;
        bus.addr    = 32'h0000_0004;
        step();
        for (int c = 0; c < 70; c++) step();
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 32'h0F0F_0F0F;
        #1;
        n_total++; if (bus.ram_req !== 1'b1) $display("FAIL nto_req_held: got %b want 1", bus.ram_req); else n_pass++;
        n_total++; if (bus.mem_err !== 1'b0) $display("FAIL nto_err: got %b want 0", bus.mem_err); else n_pass++;
        step();
        idle_inputs();
        #1;
        n_total++; if (bus.mem_ready !== 1'b1) $display("FAIL nto_ready: got %b want 1", bus.mem_ready); else n_pass++;
        n_total++; if (bus.mem_rdata !== 32'h0F0F_0F0F) $display("FAIL nto_rdata: got %h want 0f0f0f0f", bus.mem_rdata); else n_pass++;
        step();
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        idle_inputs();
        test_reset();
        test_read();
        test_write();
        test_both();
        test_back_to_back();
        test_reset_mid();
`ifdef MEMIF_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
